// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, default bit timing and data width.
// Both the receiver and the transmitter import this package.
package uart_pkg;

  localparam int unsigned UART_CLKS_PER_BIT = 434;
  localparam int unsigned UART_DATA_W       = 8;

  localparam logic [2:0] UART_ST_IDLE  = 3'd0;
  localparam logic [2:0] UART_ST_START = 3'd1;
  localparam logic [2:0] UART_ST_DATA  = 3'd2;
  localparam logic [2:0] UART_ST_STOP  = 3'd3;
  localparam logic [2:0] UART_ST_BREAK = 3'd4;

  typedef enum logic [2:0] {
    UART_IDLE  = UART_ST_IDLE,
    UART_START = UART_ST_START,
    UART_DATA  = UART_ST_DATA,
    UART_STOP  = UART_ST_STOP,
    UART_BREAK = UART_ST_BREAK
  } uart_state_e;

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for a single asynchronous input.
// The reset value is a parameter so an idle-high line starts out idle.
module uart_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver, 8N1, LSB first. Samples each bit at its centre, reports
// good bytes with a one-cycle o_irq and bad stop bits with a sticky flag.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_rxd,
  input  logic                   i_rx_finish,
  output logic [UART_DATA_W-1:0] o_rx,
  output logic                   o_irq,
  output logic                   o_rx_busy,
  output logic                   o_frame_err
);

  localparam logic [2:0] ST_IDLE  = UART_ST_IDLE;
  localparam logic [2:0] ST_START = UART_ST_START;
  localparam logic [2:0] ST_DATA  = UART_ST_DATA;
  localparam logic [2:0] ST_STOP  = UART_ST_STOP;
  localparam logic [2:0] ST_BREAK = UART_ST_BREAK;

  // Half a bit after the start edge we are at the centre of the start bit;
  // from there every full bit period lands on the centre of the next bit.
  localparam logic [15:0] HALF_M1 = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] FULL_M1 = 16'(CLKS_PER_BIT - 1);

  logic                   w_rxd_s;
  logic [2:0]             r_state;
  logic [15:0]            r_clk_cnt;
  logic [2:0]             r_bit_idx;
  logic [UART_DATA_W-1:0] r_shift;
  logic [UART_DATA_W-1:0] r_rx;
  logic                   r_irq;
  logic                   r_busy;
  logic                   r_frame_err;

  uart_sync #(
    .RST_VAL (1'b1)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (i_rxd),
    .o_q   (w_rxd_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_clk_cnt   <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_rx        <= '0;
      r_irq       <= 1'b0;
      r_busy      <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_irq  <= 1'b0;
      r_busy <= (r_state != ST_IDLE);
      // Acknowledge clears the flag; a stop-bit error below overrides it.
      if (i_rx_finish) begin
        r_frame_err <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          if (!w_rxd_s) begin
            r_state   <= ST_START;
            r_clk_cnt <= '0;
          end
        end

        ST_START: begin
          if (r_clk_cnt == HALF_M1) begin
            if (!w_rxd_s) begin
              r_state   <= ST_DATA;
              r_clk_cnt <= '0;
              r_bit_idx <= '0;
            end else begin
              r_state <= ST_IDLE;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + 16'd1;
          end
        end

        ST_DATA: begin
          if (r_clk_cnt == FULL_M1) begin
            r_shift[r_bit_idx] <= w_rxd_s;
            r_clk_cnt          <= '0;
            r_bit_idx          <= r_bit_idx + 3'd1;
            if (r_bit_idx == 3'd7) begin
              r_state <= ST_STOP;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + 16'd1;
          end
        end

        ST_STOP: begin
          if (r_clk_cnt == FULL_M1) begin
            r_clk_cnt <= '0;
            if (w_rxd_s) begin
              r_rx    <= r_shift;
              r_irq   <= 1'b1;
              r_state <= ST_IDLE;
            end else begin
              r_frame_err <= 1'b1;
              r_state     <= ST_BREAK;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + 16'd1;
          end
        end

        // Wait out a held-low line so it cannot be mistaken for new frames.
        ST_BREAK: begin
          if (w_rxd_s) begin
            r_state <= ST_IDLE;
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_rx        = r_rx;
  assign o_irq       = r_irq;
  assign o_rx_busy   = r_busy;
  assign o_frame_err = r_frame_err;

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core at 16 clocks per bit; expected bytes go
// into a scoreboard queue and are checked as o_irq pulses arrive.
module tb_uart_rx_core;

  localparam int CPB = 16;

  logic       clk;
  logic       rst_n;
  logic       i_rxd;
  logic       i_rx_finish;
  logic [7:0] o_rx;
  logic       o_irq;
  logic       o_rx_busy;
  logic       o_frame_err;

  int tests_run    = 0;
  int tests_failed = 0;

  int         cyc = 0;
  logic [7:0] exp_q[$];
  int         irq_count  = 0;
  int         irq_t_last = 0;
  int         irq_t_prev = 0;
  int         busy_cnt   = 0;
  int         ferr_rises = 0;
  logic       prev_irq   = 1'b0;
  logic       prev_ferr  = 1'b0;
  int         t_start    = 0;

  uart_rx_core #(
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_rxd       (i_rxd),
    .i_rx_finish (i_rx_finish),
    .o_rx        (o_rx),
    .o_irq       (o_irq),
    .o_rx_busy   (o_rx_busy),
    .o_frame_err (o_frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_range(input string tag, input int obs, input int lo, input int hi);
    tests_run++;
    assert (obs >= lo && obs <= hi) else begin
      tests_failed++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  // Monitor: scoreboard pops, pulse width, busy and error-edge bookkeeping.
  always @(negedge clk) begin
    if (rst_n) begin
      if (o_rx_busy) busy_cnt++;
      if (o_frame_err && !prev_ferr) ferr_rises++;
      if (o_irq) begin
        irq_count++;
        irq_t_prev = irq_t_last;
        irq_t_last = cyc;
        check("irq_single_cycle", {31'd0, prev_irq}, 32'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_irq_rx", {24'd0, o_rx}, 32'hFFFF_FFFF);
        end else begin
          check("scoreboard_rx", {24'd0, o_rx}, {24'd0, exp_q.pop_front()});
        end
      end
    end
    prev_irq  = o_irq;
    prev_ferr = o_frame_err;
  end

  task automatic hold_bit(input logic v);
    i_rxd = v;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  // Caller must be at posedge+1; returns at posedge+1 after the stop bit.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input bit push);
    if (push) exp_q.push_back(b);
    t_start = cyc;
    hold_bit(1'b0);
    for (int i = 0; i < 8; i++) hold_bit(b[i]);
    hold_bit(stop_bit);
  endtask

  task automatic idle_cycles(input int n);
    i_rxd = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int irq_before;
    int rises_before;

    rst_n       = 1'b0;
    i_rxd       = 1'b1;
    i_rx_finish = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_rx", {24'd0, o_rx}, 32'h00);
    check("reset_irq", {31'd0, o_irq}, 32'd0);
    check("reset_busy", {31'd0, o_rx_busy}, 32'd0);
    check("reset_ferr", {31'd0, o_frame_err}, 32'd0);
    rst_n = 1'b1;
    idle_cycles(10);

    // Single valid frame
    busy_cnt   = 0;
    irq_before = irq_count;
    send_frame(8'hA5, 1'b1, 1'b1);
    idle_cycles(20);
    check("a5_irq_count", irq_count - irq_before, 32'd1);
    check("a5_rx", {24'd0, o_rx}, 32'hA5);
    check("a5_ferr", {31'd0, o_frame_err}, 32'd0);
    check_range("a5_latency", irq_t_last - t_start, 154, 156);
    check_range("a5_busy_cycles", busy_cnt, 9 * CPB, 11 * CPB);
    check("a5_busy_idle", {31'd0, o_rx_busy}, 32'd0);

    // Back-to-back frames, no gap
    irq_before = irq_count;
    send_frame(8'h3C, 1'b1, 1'b1);
    send_frame(8'hFF, 1'b1, 1'b1);
    idle_cycles(20);
    check("b2b_irq_count", irq_count - irq_before, 32'd2);
    check_range("b2b_spacing", irq_t_last - irq_t_prev, 10 * CPB - 1, 10 * CPB + 1);
    check("b2b_rx_last", {24'd0, o_rx}, 32'hFF);

    // Short low glitch
    busy_cnt   = 0;
    irq_before = irq_count;
    i_rxd = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    idle_cycles(30);
    check("glitch_no_irq", irq_count - irq_before, 32'd0);
    check("glitch_rx_kept", {24'd0, o_rx}, 32'hFF);
    check_range("glitch_busy_cycles", busy_cnt, 1, 9);
    check("glitch_busy_idle", {31'd0, o_rx_busy}, 32'd0);

    // Bad stop bit followed by a held-low line
    irq_before   = irq_count;
    rises_before = ferr_rises;
    send_frame(8'h55, 1'b0, 1'b0);
    i_rxd = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check("break_ferr_set", {31'd0, o_frame_err}, 32'd1);
    check("break_busy", {31'd0, o_rx_busy}, 32'd1);
    check("break_no_irq", irq_count - irq_before, 32'd0);
    check("break_rx_kept", {24'd0, o_rx}, 32'hFF);
    idle_cycles(6);
    check("break_busy_released", {31'd0, o_rx_busy}, 32'd0);
    check("break_single_error", ferr_rises - rises_before, 32'd1);

    // Reception continues while the error flag is still set
    irq_before = irq_count;
    send_frame(8'h99, 1'b1, 1'b1);
    idle_cycles(20);
    check("ferr_rx_continues", irq_count - irq_before, 32'd1);
    check("ferr_still_sticky", {31'd0, o_frame_err}, 32'd1);

    // Acknowledge clears the flag on the following cycle
    i_rx_finish = 1'b1;
    @(posedge clk);
    #1;
    i_rx_finish = 1'b0;
    check("ack_clears_ferr", {31'd0, o_frame_err}, 32'd0);
    check("ack_keeps_rx", {24'd0, o_rx}, 32'h99);
    idle_cycles(5);

    // Reset during data bit 4 of 0x81
    irq_before = irq_count;
    i_rxd = 1'b0;
    repeat (CPB) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) hold_bit(i == 0);
    i_rxd = 1'b0;
    repeat (CPB / 2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_rx", {24'd0, o_rx}, 32'h00);
    check("midrst_irq", {31'd0, o_irq}, 32'd0);
    check("midrst_busy", {31'd0, o_rx_busy}, 32'd0);
    check("midrst_ferr", {31'd0, o_frame_err}, 32'd0);
    i_rxd = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle_cycles(CPB * 10);
    check("midrst_no_irq", irq_count - irq_before, 32'd0);
    send_frame(8'h7E, 1'b1, 1'b1);
    idle_cycles(20);
    check("after_rst_irq_count", irq_count - irq_before, 32'd1);
    check("after_rst_rx", {24'd0, o_rx}, 32'h7E);

    // Acknowledge held across a new stop-bit error: the set must win
    rises_before = ferr_rises;
    i_rx_finish  = 1'b1;
    send_frame(8'h12, 1'b0, 1'b0);
    idle_cycles(10);
    i_rx_finish = 1'b0;
    check("set_wins_over_clear", ferr_rises - rises_before, 32'd1);
    idle_cycles(2);
    check("set_wins_rx_kept", {24'd0, o_rx}, 32'h7E);

    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/uart_rx_core.md
UART_RX_CORE -- requirements
Module: uart_rx_core

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, meaning clk cycles per UART bit (50 MHz / 115200); legal range 4..65535.
REQ-002 SHALL have port clk  input  1  system clock; all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port i_rxd  input  1  asynchronous serial line, idle high.
REQ-005 SHALL have port i_rx_finish  input  1  controller acknowledge; clears sticky frame error.
REQ-006 SHALL have port o_rx  output  8  last correctly received byte.
REQ-007 SHALL have port o_irq  output  1  one-cycle pulse per valid byte.
REQ-008 SHALL have port o_rx_busy  output  1  frame in progress.
REQ-009 SHALL have port o_frame_err  output  1  sticky stop-bit error flag.

Function
REQ-010 SHALL pass i_rxd through a 2-flop synchronizer; all decisions use the synchronized value rxd_s, which resets to 1.
REQ-011 SHALL implement states IDLE, START, DATA, STOP and BREAK, with a 16-bit clk_cnt and a 3-bit bit_idx.
REQ-012 In IDLE, when rxd_s==0, SHALL go to START with clk_cnt=0.
REQ-013 In START, at clk_cnt==CLKS_PER_BIT/2-1 (integer division):
- rxd_s==0: go to DATA with clk_cnt=0, bit_idx=0.
- rxd_s==1: glitch; return to IDLE, no other output change.
REQ-014 In DATA, at each clk_cnt==CLKS_PER_BIT-1:
- sample rxd_s into shift bit bit_idx, LSB first; clk_cnt=0.
- after bit_idx==7, go to STOP; bit_idx wraps to 0.
REQ-015 In STOP, at clk_cnt==CLKS_PER_BIT-1:
- rxd_s==1: load o_rx with the shift register, pulse o_irq for exactly one cycle, go to IDLE.
- rxd_s==0: set o_frame_err, leave o_rx unchanged, no o_irq, go to BREAK.
REQ-016 In BREAK, SHALL remain until rxd_s==1, then go to IDLE; a line held low SHALL produce no further frames or errors.
REQ-017 o_rx_busy SHALL be 1 in START, DATA, STOP and BREAK, and 0 in IDLE, registered from state.
REQ-018 o_frame_err SHALL clear on the cycle after i_rx_finish==1; if set and clear coincide, set wins.
REQ-019 SHALL continue receiving while o_frame_err is set; a valid frame still pulses o_irq.
REQ-020 o_rx SHALL hold its value until the next valid frame and is not cleared by i_rx_finish.
REQ-021 Back-to-back frames SHALL be received with no idle gap beyond the stop bit: IDLE detects the next start edge on the cycle after the STOP exit.
REQ-022 Total latency SHALL be fixed: the o_irq pulse occurs at start edge + 2 sync cycles + 1 + (CLKS_PER_BIT/2) + 9*CLKS_PER_BIT cycles, +/-1.

Reset
REQ-023 rst_n low SHALL immediately force: state=IDLE, clk_cnt=0, bit_idx=0, shift=0x00, o_rx=0x00, o_irq=0, o_rx_busy=0, o_frame_err=0, synchronizer flops=1.
REQ-024 Reset asserted mid-frame SHALL abandon the frame with no o_irq; after release, reception SHALL restart at the next falling edge of rxd_s.

Structure
REQ-025 A shared package uart_pkg SHALL hold the state enumeration, the default CLKS_PER_BIT, and the data width (8); the transmitter reuses them.
REQ-026 The 2-flop synchronizer SHALL be a separate sub-module, uart_sync, with reset value a parameter (1 here).
REQ-027 The rest SHALL be a single FSM plus a datapath in uart_rx_core, 120-400 lines total.

Verification (CLKS_PER_BIT=16)
REQ-028 Send 0xA5 with a valid stop bit -> o_rx=0xA5, exactly one o_irq pulse, o_rx_busy high for about 10 bit periods, o_frame_err=0.
REQ-029 Send 0x3C then 0xFF back-to-back with no gap -> two o_irq pulses 160 +/-1 cycles apart; o_rx=0x3C, then 0xFF.
REQ-030 Drive a 5-cycle low glitch on i_rxd -> return to IDLE, no o_irq, o_rx unchanged, o_rx_busy high for at most 9 cycles.
REQ-031 Send 0x55 with stop bit 0, then hold low for 40 cycles, then high -> o_frame_err=1, no o_irq, o_rx_busy high until the line goes high; pulse i_rx_finish -> o_frame_err=0 next cycle.
REQ-032 Assert rst_n low during data bit 4 of 0x81, release, then send 0x7E -> all outputs at reset values, then o_rx=0x7E with a single o_irq.
REQ-033 Assert i_rx_finish on the same cycle a new frame error sets -> o_frame_err=1.
